sevenseg_scan: RTL and testbench

Parametrised multiplexed seven-segment scanner for N common-anode digits. It adds the following on top of plain digit muxing:
- Runtime brightness via PWM.
- Anti-ghosting blank interval at each digit switch.
- Per-digit blink.
- Tear-free double-buffered digit updates, committed only at frame boundaries.

It sits between display-formatting logic (hex/status encoders) and the board pins. All outputs are registered.

---
 rtl/sevenseg_pkg.sv | 32 +++
 rtl/sevenseg_scan_timer.sv | 46 ++++
 rtl/sevenseg_scan.sv | 118 +++++++++++
 tb/tb_sevenseg_scan.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scanner and the formatting logic
// that feeds it. Segment patterns are active-low {dp, g..a}.
package sevenseg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return {1'b1, s};
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// Slot/digit timebase: counts cycles within a digit slot, steps the selected
// digit at each slot end and flags the last cycle of the frame.
module sevenseg_scan_timer #(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYCLES = 64,
    parameter int SEL_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [SEL_W-1:0] sel,
    output logic             in_blank,
    output logic             frame_boundary
);
    localparam int          SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [31:0] BLANK_U = BLANK_CYCLES;

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              slot_end;

    assign slot_end       = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));
    assign frame_boundary = slot_end && (sel_q == SEL_W'(N_DIGITS - 1));
    assign in_blank       = ({{(32-SLOT_W){1'b0}}, slot_cnt_q} < BLANK_U);
    assign sel            = sel_q;

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        sel_d      = sel_q;
        if (slot_end) begin
            slot_cnt_d = '0;
            sel_d      = (sel_q == SEL_W'(N_DIGITS - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            sel_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            sel_q      <= sel_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness, blanking
// between digits, per-digit blink and frame-synchronous double-buffered updates.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 16384,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_LOG2   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_DIGITS*8-1:0] digits_in,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_en,
    input  logic [7:0]            brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start,
    output logic                  pending
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_digits
        $error("sevenseg_scan: N_DIGITS must be in 1..16");
    end
    if (SCAN_DIV <= BLANK_CYCLES) begin : g_bad_div
        $error("sevenseg_scan: SCAN_DIV must exceed BLANK_CYCLES");
    end

    logic [SEL_W-1:0] sel;
    logic             in_blank;
    logic             frame_boundary;

    sevenseg_scan_timer #(
        .N_DIGITS     (N_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .SEL_W        (SEL_W)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .sel            (sel),
        .in_blank       (in_blank),
        .frame_boundary (frame_boundary)
    );

    seg_t [N_DIGITS-1:0] active_q, pend_buf_q;
    logic                pending_q;
    logic [7:0]          bright_q, pwm_q;
    logic [BLINK_LOG2:0] blink_q;
    logic                start_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                fs_q;
    seg_t                cur;
    logic                lit;

    always_comb begin
        cur   = active_q[sel];
        lit   = digit_en[sel] && !in_blank && (pwm_q < bright_q)
                && !(blink_en[sel] && blink_q[BLINK_LOG2]);
        an_d  = '1;
        seg_d = SEG_BLANK[6:0];
        dp_d  = 1'b1;
        if (lit) begin
            an_d  = ~(N_DIGITS'(1) << sel);
            seg_d = cur[6:0];
            dp_d  = cur[7];
        end
    end

    // start_q marks the cycle whose state is digit 0, slot 0 (right after reset
    // or right after a frame boundary); it is delayed once more onto the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= {N_DIGITS{SEG_BLANK}};
            pend_buf_q <= {N_DIGITS{SEG_BLANK}};
            pending_q  <= 1'b0;
            bright_q   <= 8'd0;
            pwm_q      <= 8'd0;
            blink_q    <= '0;
            start_q    <= 1'b1;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            fs_q       <= 1'b0;
        end else begin
            pwm_q   <= pwm_q + 8'd1;
            blink_q <= blink_q + 1'b1;
            start_q <= frame_boundary;
            if (frame_boundary) begin
                bright_q <= brightness;
                if (pending_q) active_q <= pend_buf_q;
            end
            if (load) begin
                pend_buf_q <= digits_in;
                pending_q  <= 1'b1;
            end else if (frame_boundary) begin
                pending_q <= 1'b0;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= start_q;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: cycle-indexed reference model checked every cycle,
// directed tables and counted windows for the scan, buffer, PWM and blink cases.
module tb_sevenseg_scan;
    import sevenseg_pkg::*;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BL = 5;
    localparam int FRAME = N * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   digits_in = '0;
    logic          load = 1'b0;
    logic [3:0]    digit_en = 4'h0;
    logic [3:0]    blink_en = 4'h0;
    logic [7:0]    brightness = 8'd0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp, frame_start, pending;

    always #5 clk = ~clk;

    sevenseg_scan #(
        .N_DIGITS     (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_LOG2   (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .load        (load),
        .digit_en    (digit_en),
        .blink_en    (blink_en),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start),
        .pending     (pending)
    );

    int checks = 0;
    int errors = 0;
    int steps  = 0;
    int last_fs = -1;

    // Reference model: mc is the number of non-reset cycles since reset, so
    // slot, digit, pwm and blink phase all follow from plain arithmetic on it.
    int          mc = 0;
    logic [7:0]  m_active [N];
    logic [7:0]  m_pend   [N];
    logic        m_pending = 1'b0;
    logic [7:0]  m_bright = 8'd0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, e_pend;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl [FRAME];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (step %0d, model cycle %0d)", name, act, exp, steps, mc);
        end
    endtask

    task automatic model_step();
        int  slot, sel, pwm;
        bit  boff, lit;
        if (rst) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_pend = 1'b0;
            mc = 0; m_pending = 1'b0; m_bright = 8'd0;
            for (int i = 0; i < N; i++) begin
                m_active[i] = 8'hFF;
                m_pend[i]   = 8'hFF;
            end
        end else begin
            slot = mc % SD;
            sel  = (mc / SD) % N;
            pwm  = mc % 256;
            boff = (mc % (2 ** (BL + 1))) >= (2 ** BL);
            lit  = digit_en[sel] && (slot >= BC) && (pwm < int'(m_bright))
                   && !(blink_en[sel] && boff);
            if (lit) begin
                e_an  = ~(4'b0001 << sel);
                e_seg = m_active[sel][6:0];
                e_dp  = m_active[sel][7];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_fs = (mc % FRAME) == 0;
            if ((mc % FRAME) == FRAME - 1) begin
                m_bright = brightness;
                if (m_pending) for (int i = 0; i < N; i++) m_active[i] = m_pend[i];
                m_pending = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_pend[i] = digits_in[8*i +: 8];
                m_pending = 1'b1;
            end
            e_pend = m_pending;
            mc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        steps++;
        chk("an", {28'd0, an}, {28'd0, e_an});
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("dp", {31'd0, dp}, {31'd0, e_dp});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        chk("pending", {31'd0, pending}, {31'd0, e_pend});
        if (rst) last_fs = -1;
        else if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("fs_period", steps - last_fs, FRAME);
            last_fs = steps;
        end
    endtask

    task automatic goto(input int target);
        int guard = 0;
        while (mc != target && guard < 4000) begin
            step();
            guard++;
        end
        if (mc != target) begin
            errors++;
            $display("FAIL goto: reached cycle %0d expected %0d", mc, target);
        end
    endtask

    // which = 0..3 counts cycles with that anode low; 4 counts any anode low.
    task automatic run_count(input int n, input int which, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (which == 4) begin
                if (an !== 4'hF) cnt++;
            end else if (an[which] === 1'b0) cnt++;
        end
    endtask

    initial begin
        logic [3:0]  dig_an  [N];
        logic [6:0]  dig_seg [N];
        logic [7:0]  d1 [N];
        logic [7:0]  d2 [N];
        logic [3:0]  hx [6];
        logic [7:0]  hx_exp [6];
        int          cnt, cnt2;

        dig_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        dig_seg = '{7'h40, 7'h79, 7'h24, 7'h30};
        d1      = '{8'h78, 8'h02, 8'h12, 8'h19};
        d2      = '{8'h03, 8'h08, 8'h10, 8'h00};
        hx      = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hF};
        hx_exp  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h80, 8'h8E};
        for (int p = 0; p < FRAME; p++) begin
            tbl[p].an  = ((p % SD) < BC) ? 4'hF  : dig_an[p / SD];
            tbl[p].seg = ((p % SD) < BC) ? 7'h7F : dig_seg[p / SD];
        end

        for (int i = 0; i < 6; i++) chk("hex_to_seg", {24'd0, hex_to_seg(hx[i])}, {24'd0, hx_exp[i]});

        // Reset hold, then release with display enabled but bright_q still 0.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0; digit_en = 4'hF; brightness = 8'd255;
        run_count(FRAME, 4, cnt);
        chk("dark_first_frame", cnt, 0);

        // Mid-frame load; pending held until the boundary commits it.
        goto(40);
        digits_in = {8'hB0, 8'hA4, 8'hF9, 8'hC0}; load = 1'b1;
        step();
        load = 1'b0;
        chk("pending_after_load", {31'd0, pending}, 1);
        goto(63);
        chk("pending_before_boundary", {31'd0, pending}, 1);
        step();
        chk("pending_after_boundary", {31'd0, pending}, 0);

        for (int p = 0; p < FRAME; p++) begin
            step();
            chk("scan_an", {28'd0, an}, {28'd0, tbl[p].an});
            chk("scan_seg", {25'd0, seg}, {25'd0, tbl[p].seg});
        end

        // Load on the boundary cycle: old pending commits, new one waits a frame.
        goto(110);
        digits_in = {d1[3], d1[2], d1[1], d1[0]}; load = 1'b1;
        step();
        load = 1'b0;
        goto(127);
        digits_in = {d2[3], d2[2], d2[1], d2[0]}; load = 1'b1;
        step();
        load = 1'b0;
        chk("pending_held", {31'd0, pending}, 1);
        goto(130);
        step();
        chk("old_pending_shown", {25'd0, seg}, {25'd0, d1[0][6:0]});
        goto(159);
        chk("pending_across_frame", {31'd0, pending}, 1);
        step();
        chk("pending_cleared", {31'd0, pending}, 0);
        goto(162);
        step();
        chk("new_data_shown", {25'd0, seg}, {25'd0, d2[0][6:0]});

        // Brightness changes mid-frame only take effect at the next frame.
        goto(170);
        brightness = 8'd0;
        goto(178);
        step();
        chk("duty_held_mid_frame", {28'd0, an}, 32'hB);
        goto(192);
        run_count(58, 4, cnt);
        brightness = 8'd128;
        run_count(6, 4, cnt2);
        chk("bright0_dark", cnt + cnt2, 0);
        run_count(FRAME, 4, cnt);
        chk("bright128_low_pwm", cnt, 24);
        goto(384);
        run_count(FRAME, 4, cnt);
        chk("bright128_high_pwm", cnt, 0);

        // Blink on digit 1 only.
        goto(416);
        brightness = 8'd255;
        goto(448);
        blink_en = 4'b0010;
        run_count(128, 1, cnt);
        chk("blink_digit1", cnt, 12);
        goto(576);
        blink_en = 4'b0000;
        digit_en = 4'b1011;
        run_count(64, 2, cnt);
        chk("digit2_disabled", cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) digits_in = $urandom();
            if ($urandom_range(0, 15) == 0) brightness = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blink_en = 4'($urandom_range(0, 15));
            step();
        end
        load = 1'b0;
        digit_en = 4'hF;
        blink_en = 4'h0;
        brightness = 8'd255;

        // Reset in the middle of a slot with a load pending.
        goto(mc - (mc % SD) + SD + 4);
        digits_in = 32'h12345678; load = 1'b1;
        step();
        load = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_pending", {31'd0, pending}, 0);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
